// File: rtl/chrisruk_apa102_glyph.sv
`default_nettype none
// ============================================================================
// Module   : chrisruk_apa102_glyph
// Brief    : APA102 serial framer that renders one a-z font glyph on an
//            8x8 LED matrix with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module chrisruk_apa102_glyph #(
    parameter int NUM_LEDS   = 64,
    parameter int CLK_DIV    = 1,
    parameter int END_BITS   = 32,
    parameter int SERPENTINE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  char_idx,
    input  logic [23:0] fg_rgb,
    input  logic [23:0] bg_rgb,
    input  logic [4:0]  brightness,
    output logic        sclk,
    output logic        sdata,
    output logic        busy,
    output logic        done
);

    localparam int c_LED_BITS = 32 * NUM_LEDS;
    localparam int c_SEC_MAX  = (c_LED_BITS > END_BITS) ? c_LED_BITS : END_BITS;
    localparam int c_CNT_W    = $clog2(c_SEC_MAX + 1);
    localparam int c_PAD_W    = (c_CNT_W > 11) ? c_CNT_W : 11;
    localparam int c_PH_W     = $clog2(2 * CLK_DIV);

    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(31);
    localparam logic [c_CNT_W-1:0] c_LED_LAST   = c_CNT_W'(c_LED_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_END_LAST   = c_CNT_W'(END_BITS - 1);
    localparam logic [c_PH_W-1:0]  c_PH_RISE    = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST    = c_PH_W'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_LED   = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_PH_W-1:0]    r_phase, w_phase_nxt;
    logic                 r_sclk, w_sclk_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_sdata;
    logic                 w_load, w_shift, w_bit;
    logic [4:0]           r_char;
    logic [23:0]          r_fg, r_bg;
    logic [4:0]           r_bright;

    logic [c_PAD_W-1:0]   w_pos;
    logic [2:0]           w_row, w_col;
    logic                 w_lit;
    logic [23:0]          w_rgb;
    logic [31:0]          w_word;
    logic [63:0]          w_glyph;

    // Rows are stored top row in the most significant byte, column 0 in bit 0.
    function automatic logic [63:0] glyph_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    glyph_rom = 64'h00001E303E336E00;
            5'd1:    glyph_rom = 64'h0706063E66663B00;
            5'd2:    glyph_rom = 64'h00001E3303331E00;
            5'd3:    glyph_rom = 64'h3830303E33336E00;
            5'd4:    glyph_rom = 64'h00001E333F031E00;
            5'd5:    glyph_rom = 64'h1C36060F06060F00;
            5'd6:    glyph_rom = 64'h00006E33333E301F;
            5'd7:    glyph_rom = 64'h0706366E66666700;
            5'd8:    glyph_rom = 64'h0C000E0C0C0C1E00;
            5'd9:    glyph_rom = 64'h300030303033331E;
            5'd10:   glyph_rom = 64'h070666361E366700;
            5'd11:   glyph_rom = 64'h0E0C0C0C0C0C1E00;
            5'd12:   glyph_rom = 64'h0000337F7F6B6300;
            5'd13:   glyph_rom = 64'h00001F3333333300;
            5'd14:   glyph_rom = 64'h00001E3333331E00;
            5'd15:   glyph_rom = 64'h00003B66663E060F;
            5'd16:   glyph_rom = 64'h00006E33333E3078;
            5'd17:   glyph_rom = 64'h00003B6E66060F00;
            5'd18:   glyph_rom = 64'h00003E031E301F00;
            5'd19:   glyph_rom = 64'h080C3E0C0C2C1800;
            5'd20:   glyph_rom = 64'h0000333333336E00;
            5'd21:   glyph_rom = 64'h00003333331E0C00;
            5'd22:   glyph_rom = 64'h0000636B7F7F3600;
            5'd23:   glyph_rom = 64'h000063361C366300;
            5'd24:   glyph_rom = 64'h00003333333E301F;
            5'd25:   glyph_rom = 64'h00003F190C263F00;
            default: glyph_rom = 64'h0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_sclk   <= 1'b0;
            r_sdata  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_char   <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_bright <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_sclk  <= w_sclk_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_shift) r_sdata <= w_bit;
            if (w_load) begin
                r_char   <= char_idx;
                r_fg     <= fg_rgb;
                r_bg     <= bg_rgb;
                r_bright <= brightness;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_sclk_nxt  = r_sclk;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        if (r_state == S_IDLE) begin
            if (start) begin
                w_load      = 1'b1;
                w_shift     = 1'b1;
                w_state_nxt = S_START;
                w_cnt_nxt   = '0;
                w_phase_nxt = '0;
                w_sclk_nxt  = 1'b0;
                w_busy_nxt  = 1'b1;
            end
        end else if (r_phase == c_PH_RISE) begin
            w_sclk_nxt  = 1'b1;
            w_phase_nxt = r_phase + 1'b1;
        end else if (r_phase == c_PH_LAST) begin
            // Falling sclk closes the bit; the next bit is presented on the same edge.
            w_sclk_nxt  = 1'b0;
            w_phase_nxt = '0;
            w_shift     = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
            case (r_state)
                S_START: if (r_cnt == c_START_LAST) begin
                    w_state_nxt = S_LED;
                    w_cnt_nxt   = '0;
                end
                S_LED: if (r_cnt == c_LED_LAST) begin
                    w_state_nxt = S_END;
                    w_cnt_nxt   = '0;
                end
                default: if (r_cnt == c_END_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            endcase
        end else begin
            w_phase_nxt = r_phase + 1'b1;
        end
    end

    // Bit source for the position the counter is about to enter.
    always_comb begin
        w_pos   = c_PAD_W'(w_cnt_nxt);
        w_row   = w_pos[10:8];
        w_col   = ((SERPENTINE != 0) && w_row[0]) ? ~w_pos[7:5] : w_pos[7:5];
        w_glyph = glyph_rom(r_char);
        w_lit   = ((w_pos >> 11) == '0) && w_glyph[{~w_row, w_col}];
        w_rgb   = w_lit ? r_fg : r_bg;
        w_word  = {3'b111, r_bright, w_rgb[7:0], w_rgb[15:8], w_rgb[23:16]};
        case (w_state_nxt)
            S_LED:   w_bit = w_word[~w_pos[4:0]];
            S_END:   w_bit = 1'b1;
            default: w_bit = 1'b0;
        endcase
    end

    assign sclk  = r_sclk;
    assign sdata = r_sdata;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chrisruk_apa102_glyph.sv
`default_nettype none
// ============================================================================
// Module   : tb_chrisruk_apa102_glyph
// Brief    : Directed self-checking bench for the APA102 glyph framer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chrisruk_apa102_glyph;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0, start_s = 1'b0, start_d = 1'b0;
    logic [4:0]  char_idx = '0;
    logic [23:0] fg_rgb = '0, bg_rgb = '0;
    logic [4:0]  brightness = '0;
    logic        sclk_a, sdata_a, busy_a, done_a;
    logic        sclk_s, sdata_s, busy_s, done_s;
    logic        sclk_d, sdata_d, busy_d, done_d;

    int checks = 0;
    int failures = 0;
    bit frame_bits [0:4095];
    int rises, busy_cnt, dones, first_busy, stable_err, period, first_rise;

    always #5 clk = ~clk;

    chrisruk_apa102_glyph u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .char_idx(char_idx),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .brightness(brightness),
        .sclk(sclk_a), .sdata(sdata_a), .busy(busy_a), .done(done_a)
    );

    chrisruk_apa102_glyph #(.SERPENTINE(1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .char_idx(char_idx),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .brightness(brightness),
        .sclk(sclk_s), .sdata(sdata_s), .busy(busy_s), .done(done_s)
    );

    chrisruk_apa102_glyph #(.CLK_DIV(3)) u_dut_d (
        .clk(clk), .reset_n(reset_n), .start(start_d), .char_idx(char_idx),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .brightness(brightness),
        .sclk(sclk_d), .sdata(sdata_d), .busy(busy_d), .done(done_d)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        start_a = (sel == 0) && v;
        start_s = (sel == 1) && v;
        start_d = (sel == 2) && v;
    endtask

    function automatic logic [31:0] word_at(input int base);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            if (base + b >= 0 && base + b < 4096) w = {w[30:0], frame_bits[base + b]};
        end
        return w;
    endfunction

    // Samples one frame on falling clock edges, recording sdata at every sclk rise.
    task automatic run_frame(input int sel, input bit issue_start, input int pulse_at, input bit chain);
        logic sc, sd, bz, dn, prev_sc, prev_sd;
        rises = 0; busy_cnt = 0; dones = 0; stable_err = 0; period = 0;
        first_rise = -1; first_busy = 0; prev_sc = 1'b0; prev_sd = 1'b0;
        if (issue_start) begin
            @(negedge clk);
            set_start(sel, 1'b1);
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            set_start(sel, cyc == pulse_at);
            if (cyc == pulse_at) begin
                char_idx = 5'd0;
                fg_rgb   = 24'hFFFFFF;
                bg_rgb   = 24'hABCDEF;
            end
            sc = (sel == 0) ? sclk_a  : (sel == 1) ? sclk_s  : sclk_d;
            sd = (sel == 0) ? sdata_a : (sel == 1) ? sdata_s : sdata_d;
            bz = (sel == 0) ? busy_a  : (sel == 1) ? busy_s  : busy_d;
            dn = (sel == 0) ? done_a  : (sel == 1) ? done_s  : done_d;
            if (cyc == 0) first_busy = int'(bz);
            if (bz) busy_cnt++;
            if (sc && !prev_sc) begin
                if (rises < 4096) frame_bits[rises] = sd;
                if (sd !== prev_sd) stable_err++;
                if (first_rise < 0) first_rise = cyc;
                else if (period == 0) period = cyc - first_rise;
                rises++;
            end
            prev_sc = sc;
            prev_sd = sd;
            if (dn) begin
                dones++;
                if (chain) set_start(sel, 1'b1);
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({sclk_a, sdata_a, busy_a, done_a}), 64'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort a frame with an asynchronous reset
        char_idx = 5'd0; brightness = 5'h1F; fg_rgb = 24'hFF0000; bg_rgb = 24'h0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        chk("busy_before_abort", 64'(busy_a), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({sclk_a, sdata_a, busy_a, done_a}), 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sclk_a || sdata_a || busy_a || done_a) cnt++;
        end
        chk("post_abort_activity", 64'(cnt), 64'h0);

        // Glyph 'a', default parameters, chained into a second frame
        char_idx = 5'd0; brightness = 5'h1F; fg_rgb = 24'hFF0000; bg_rgb = 24'h0;
        run_frame(0, 1'b1, -1, 1'b1);
        chk("a_rises", 64'(rises), 64'd2112);
        chk("a_busy_cycles", 64'(busy_cnt), 64'd4224);
        chk("a_done_pulses", 64'(dones), 64'd1);
        chk("a_start_frame", 64'(word_at(0)), 64'h0);
        chk("a_led0", 64'(word_at(32)), 64'hFF000000);
        chk("a_led18", 64'(word_at(32 + 18 * 32)), 64'hFF0000FF);
        chk("a_end_frame", 64'(word_at(rises - 32)), 64'hFFFFFFFF);
        run_frame(0, 1'b0, -1, 1'b0);
        chk("chain_first_cycle_busy", 64'(first_busy), 64'h1);
        chk("chain_rises", 64'(rises), 64'd2112);
        chk("chain_busy_cycles", 64'(busy_cnt), 64'd4224);
        chk("chain_led18", 64'(word_at(32 + 18 * 32)), 64'hFF0000FF);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
        chk("chain_no_extra_done", 64'(cnt), 64'h0);

        // Blank glyph with a start pulse and input changes mid-frame
        char_idx = 5'd30; brightness = 5'h1F; fg_rgb = 24'hFF0000; bg_rgb = 24'h123456;
        run_frame(0, 1'b1, 500, 1'b0);
        chk("blank_rises", 64'(rises), 64'd2112);
        chk("blank_busy_cycles", 64'(busy_cnt), 64'd4224);
        bad = 0;
        for (int led = 0; led < 64; led++) begin
            if (word_at(32 + led * 32) != 32'hFF563412) bad++;
        end
        chk("blank_bad_words", 64'(bad), 64'h0);

        // Serpentine glyph 'l'
        char_idx = 5'd11; brightness = 5'h1F; fg_rgb = 24'h00FF00; bg_rgb = 24'h0;
        run_frame(1, 1'b1, -1, 1'b0);
        chk("serp_led0", 64'(word_at(32 + 0 * 32)), 64'hFF000000);
        chk("serp_led1", 64'(word_at(32 + 1 * 32)), 64'hFF00FF00);
        chk("serp_led2", 64'(word_at(32 + 2 * 32)), 64'hFF00FF00);
        chk("serp_led3", 64'(word_at(32 + 3 * 32)), 64'hFF00FF00);
        chk("serp_led4", 64'(word_at(32 + 4 * 32)), 64'hFF000000);
        chk("serp_led8", 64'(word_at(32 + 8 * 32)), 64'hFF000000);
        chk("serp_led11", 64'(word_at(32 + 11 * 32)), 64'hFF000000);
        chk("serp_led12", 64'(word_at(32 + 12 * 32)), 64'hFF00FF00);
        chk("serp_led13", 64'(word_at(32 + 13 * 32)), 64'hFF00FF00);

        // Clock divider of 3
        char_idx = 5'd0; brightness = 5'h1F; fg_rgb = 24'hFF0000; bg_rgb = 24'h0;
        run_frame(2, 1'b1, -1, 1'b0);
        chk("div_rises", 64'(rises), 64'd2112);
        chk("div_busy_cycles", 64'(busy_cnt), 64'd12672);
        chk("div_sclk_period", 64'(period), 64'd6);
        chk("div_sdata_unstable", 64'(stable_err), 64'h0);
        chk("div_led18", 64'(word_at(32 + 18 * 32)), 64'hFF0000FF);
        chk("div_done_pulses", 64'(dones), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/chrisruk_apa102_glyph.md
Name: chrisruk_apa102_glyph

Overview:
Parametrised APA102-style serial LED driver for an 8x8 matrix that renders one glyph from an internal 26-entry lowercase a-z font ROM. It generalises the fixed 64-LED strip framer with configurable LED count, serial clock divider, end-frame length, serpentine wiring, foreground/background colour, global brightness and a start/busy/done handshake. It sits between the chip IO pins and the strip's CI/DI inputs.

Parameters:
NUM_LEDS, 64, LEDs in chain; pixels with index >= 64 are always background.
CLK_DIV, 1, clk cycles per sclk half-period (>= 1).
END_BITS, 32, end-frame length in bits, all ones; must be >= NUM_LEDS/2.
SERPENTINE, 0, 1 = odd glyph rows are column-reversed in LED order.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle frame request; sampled only in IDLE.
char_idx  input  5  glyph 0..25 = 'a'..'z'; values 26..31 render blank.
fg_rgb  input  24  {R,G,B} colour for lit pixels.
bg_rgb  input  24  {R,G,B} colour for unlit pixels.
brightness  input  5  APA102 global brightness field.
sclk  output  1  strip clock.
sdata  output  1  strip data, MSB first.
busy  output  1  high while a frame is being shifted.
done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, reset_n low): sclk=0, sdata=0, busy=0, done=0, FSM=IDLE, all counters 0. Reset mid-frame aborts it immediately; no done pulse.
- Font ROM: glyph g is 64 bits; byte r (r=0 is bits 63:56) is row r; bit c of that byte is column c (bit 0 = column 0). Glyph 'a' = 64'h00001E303E336E00; 'l' = 64'h0E0C0C0C0C0C1E00.
- Pixel mapping: LED index p -> row r=p/8; column c=p%8, or 7-(p%8) when SERPENTINE=1 and r odd. Lit = ROM bit set.
- Handshake: start high in IDLE at cycle T latches char_idx, fg_rgb, bg_rgb and brightness. busy=1 from T+1. start while busy is ignored. Inputs may change freely after T.
- FSM: IDLE -> START_FRAME (32 zero bits) -> LED_FRAME (NUM_LEDS x 32 bits) -> END_FRAME (END_BITS one bits) -> IDLE.
- LED word (MSB first): 3'b111, brightness[4:0], B[7:0], G[7:0], R[7:0]. Colour is fg if lit, else bg.
- Bit timing: each bit occupies 2*CLK_DIV cycles.
  - sdata is updated only while sclk is low, at the start of the bit (first bit at T+1).
  - sclk rises CLK_DIV cycles later and falls after a further CLK_DIV cycles, which is the start of the next bit.
- Frame length: TOTAL_BITS = 32 + 32*NUM_LEDS + END_BITS. busy stays high for exactly TOTAL_BITS*2*CLK_DIV cycles.
- End of frame: on the cycle after the last sclk fall, busy=0, done=1 for that one cycle, sdata=0, sclk=0.
- Back-to-back frames: start is accepted in the same cycle done is high, so frames chain with no gap.
- Counter widths: sized from the parameters with $clog2; no wrap occurs inside a frame.

Test Plan:
- Reset: hold reset_n=0 mid-frame, then release -> sclk=0, sdata=0, busy=0, done=0; no sclk edges until the next start.
- Frame length, defaults, CLK_DIV=1: one start -> 2112 sclk rising edges; busy high for 4224 cycles; exactly one done pulse.
- Framing: char_idx=0, brightness=5'h1F, fg=24'hFF0000, bg=0.
  - Start frame: first 32 sampled bits are 0.
  - LED0 (unlit): word = 32'hFF000000.
  - LED 18 (row 2, col 2; row byte 0x1E, lit): word = 32'hFF0000FF.
  - End frame: last 32 bits are 1.
- Serpentine: SERPENTINE=1, char_idx=11, fg=24'h00FF00, bg=0.
  - Row 0 = 0x0E: LEDs 1-3 lit.
  - Row 1 = 0x0C, reversed: LEDs 12-13 lit (0x00FF00 -> word 32'hFF00FF00); LED 8 unlit.
- Blank and ignored start: char_idx=30 -> all 64 LED words use bg. Pulsing start while busy does not change frame length or contents.
- Divider and chaining: CLK_DIV=3 -> sclk period 6 cycles and sdata stable across each rising edge. start asserted on the done cycle -> the next frame's first bit is driven on the following cycle.
